mrd_bfp_align: RTL and testbench
================================

Name: mrd_bfp_align

Overview:
- Sits downstream of the mixed-radix butterfly stages.
- Collects one frame of block-floating-point samples, each carrying its own 4-bit exponent.
- Aligns every sample to the frame's largest exponent, then streams the frame out with one common exponent.
- Computes the headroom (margin) of the aligned frame, which the next radix stage consumes as its margin input.

Parameters:
- FRAME_MAX, 1200: buffer depth in samples; also the maximum frame length.
- AW, $clog2(FRAME_MAX): buffer address width.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- in_val  in  1  input sample valid
- in_sop  in  1  first sample of frame
- in_eop  in  1  last sample of frame
- din_real  in  18  signed sample, real part
- din_imag  in  18  signed sample, imag part
- exp_in  in  4  unsigned per-sample exponent
- in_rdy  out  1  block can accept samples
- out_val  out  1  output sample valid
- out_sop  out  1  first output sample
- out_eop  out  1  last output sample
- dout_real  out  18  aligned sample, real part
- dout_imag  out  18  aligned sample, imag part
- exp_out  out  4  frame exponent
- margin_out  out  2  frame headroom, 0..3
- err_ovf  out  1  one-cycle pulse: frame exceeded FRAME_MAX

Behaviour:
- Reset: rst_n is synchronous, active-low; clock is clk. While rst_n=0, every output is 0 and the FSM goes to IDLE. The cycle after release, in_rdy=1. Reset mid-frame discards the frame; no partial output follows.
- FSM:
  - IDLE: in_rdy=1. Accepted in_val&in_sop writes address 0 and goes to FILL. in_val without in_sop is ignored. in_sop&in_eop together forms a 1-sample frame and goes straight to DRAIN.
  - FILL: in_rdy=1. Each in_val writes the next address. in_eop goes to DRAIN. in_sop in FILL restarts the frame at address 0 and clears the trackers.
  - DRAIN: in_rdy=0. Reads addresses 0..len-1, one per cycle, then returns to IDLE. in_rdy=1 from the cycle after out_eop.
- Fill trackers:
  - max_exp = max of exp_in over the frame.
  - rsb_i = redundant sign bits of the sample = min over real and imag of (leading equal bits − 1), range 0..17.
  - mt = min over the frame of (rsb_i − exp_i), signed 6-bit.
- Overflow: samples beyond FRAME_MAX are dropped and do not update the trackers. err_ovf pulses once at the first dropped sample. eop still ends the frame; len = FRAME_MAX.
- Alignment: d = max_exp − exp_i.
  - d=0: pass through unchanged.
  - 1≤d≤17: arithmetic shift right by d, then add bit d−1 (round half up). No overflow is possible.
  - d≥18: output 0.
- Drain outputs:
  - exp_out = max_exp, held from out_sop through out_eop, 0 otherwise.
  - margin_out = clamp(mt + max_exp, 0, 3), held over the frame like exp_out.
  - out_sop on the first sample, out_eop on the last.
- Latency: 2 cycles from the DRAIN-entry edge to out_val (RAM read plus shift register). out_val is continuous for len cycles.
- No output back-pressure.
- Input and output never overlap because there is a single buffer.

Optional Feature:
- MRD_BFP_ALIGN_RND_EN:
  - Defined: round-half-up as above.
  - Undefined: plain truncation (arithmetic shift only), and the adder is removed.
- All other behaviour is identical in both builds.

Decomposition:
- Shared package mrd_pkg holds:
  - DW=18, EXPW=4, MARGIN_MAX=2'd3
  - typedef cplx_t {signed [DW-1:0] re, im}
  - function rsb(), the redundant-sign-bit count
- One sub-module, mrd_sdp_ram: simple dual-port RAM, 1-cycle read latency, 40-bit word = {exp, re, im}, depth FRAME_MAX.

Test Plan:
- Equal exponents: 4-sample frame, all exp_in=2, data 1000, -1000, 5, 0. Output is identical data, exp_out=2, out_val 2 cycles after DRAIN entry.
- Mixed exponents: samples (exp 0, re 400) and (exp 3, re 100). Outputs re 50 and 100, exp_out=3. With the macro undefined, same values (exact shifts).
- Rounding: exp 0, re=7 against max_exp 1. Output 4 when MRD_BFP_ALIGN_RND_EN is defined, 3 when undefined; re=-7 gives -3 and -4 respectively.
- Margin: all samples ±1024 (rsb 6) with exp 0, except one sample with exp 4. mt=2, margin_out=clamp(2+4)=3. Full-scale 131071 with exp 0 only gives margin_out=0.
- Overflow: FRAME_MAX=8, 10-sample frame. err_ovf pulses at sample 9, output is 8 samples, out_eop on the 8th.
- Reset mid-FILL: after 3 samples, pulse rst_n low. No output appears; the next frame of 2 samples outputs correctly with out_sop/out_eop.

Source files
------------

// File: rtl/mrd_pkg.sv
// rtl/mrd_pkg.sv - shared widths, complex sample type and sign-bit helper for the mixed-radix datapath
package mrd_pkg;

  localparam int DW = 18;
  localparam int EXPW = 4;
  localparam logic [1:0] MARGIN_MAX = 2'd3;

  typedef struct packed {
    logic signed [DW-1:0] re;
    logic signed [DW-1:0] im;
  } cplx_t;

  // Count of sign-bit copies directly below the MSB (0 for full scale, DW-1 for 0 / -1).
  function automatic logic [4:0] rsb(input logic signed [DW-1:0] x);
    logic [4:0] n;
    logic       run;
    n   = '0;
    run = 1'b1;
    for (int i = DW - 2; i >= 0; i--) begin
      if (run && (x[i] == x[DW-1])) n = n + 5'd1;
      else run = 1'b0;
    end
    return n;
  endfunction

endpackage

// File: rtl/mrd_sdp_ram.sv
// rtl/mrd_sdp_ram.sv - simple dual-port frame buffer, one write port, registered read port
module mrd_sdp_ram
  import mrd_pkg::*;
#(
  parameter int DEPTH = 1200,
  parameter int AW    = $clog2(DEPTH),
  parameter int WW    = EXPW + 2 * DW
) (
  input  logic          clk,
  input  logic          wr_en_i,
  input  logic [AW-1:0] wr_addr_i,
  input  logic [WW-1:0] wr_data_i,
  input  logic          rd_en_i,
  input  logic [AW-1:0] rd_addr_i,
  output logic [WW-1:0] rd_data_o
);

  logic [WW-1:0] mem_q [DEPTH];
  logic [WW-1:0] rd_data_q;

  // Write port and one-cycle-latency read port share the clock.
  always_ff @(posedge clk) begin
    if (wr_en_i) mem_q[wr_addr_i] <= wr_data_i;
    if (rd_en_i) rd_data_q <= mem_q[rd_addr_i];
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/mrd_bfp_align.sv
// rtl/mrd_bfp_align.sv - block-floating-point frame aligner; MRD_BFP_ALIGN_RND_EN selects round-half-up over truncation
module mrd_bfp_align
  import mrd_pkg::*;
#(
  parameter int FRAME_MAX = 1200,
  parameter int AW        = $clog2(FRAME_MAX)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_val,
  input  logic                 in_sop,
  input  logic                 in_eop,
  input  logic signed [DW-1:0] din_real,
  input  logic signed [DW-1:0] din_imag,
  input  logic [EXPW-1:0]      exp_in,
  output logic                 in_rdy,
  output logic                 out_val,
  output logic                 out_sop,
  output logic                 out_eop,
  output logic signed [DW-1:0] dout_real,
  output logic signed [DW-1:0] dout_imag,
  output logic [EXPW-1:0]      exp_out,
  output logic [1:0]           margin_out,
  output logic                 err_ovf
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FILL  = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  localparam int          WW      = EXPW + 2 * DW;
  localparam logic [AW:0] LEN_MAX = (AW+1)'(FRAME_MAX);
  localparam logic [AW:0] CNT_ONE = (AW+1)'(1);
  localparam logic [EXPW:0] D_FLUSH = (EXPW+1)'(DW);
`ifdef MRD_BFP_ALIGN_RND_EN
  localparam logic [EXPW:0] D_ONE = (EXPW+1)'(1);
`endif

  logic [1:0]            state_q, state_d;
  logic                  in_rdy_q;
  logic [AW:0]           wr_cnt_q, wr_cnt_d;
  logic [AW:0]           rd_cnt_q, rd_cnt_d;
  logic [EXPW-1:0]       max_exp_q, max_exp_d;
  logic signed [5:0]     mt_q, mt_d;
  logic                  ovf_q, ovf_d;
  logic                  err_ovf_q;
  logic                  s1_val_q, s1_sop_q, s1_eop_q;
  logic                  out_val_q, out_sop_q, out_eop_q;
  logic signed [DW-1:0]  dout_re_q, dout_im_q;

  logic                  accept, start, in_fill, drop, upd, wr_en, rd_en, rd_last;
  logic [AW-1:0]         wr_addr;
  logic [4:0]            rsb_re, rsb_im, smp_rsb;
  logic signed [5:0]     smp_key;
  cplx_t                 w_smp, r_smp;
  logic [WW-1:0]         rd_data;
  logic [EXPW-1:0]       r_exp;
  logic [EXPW:0]         d;
  logic signed [6:0]     msum;

  // Shift right by the exponent gap; the rounding build adds back the last bit shifted out.
  function automatic logic signed [DW-1:0] align(input logic signed [DW-1:0] val,
                                                 input logic [EXPW:0] sh_amt);
    logic signed [DW-1:0] y;
`ifdef MRD_BFP_ALIGN_RND_EN
    logic [EXPW:0] dm1;
    dm1 = sh_amt - D_ONE;
`endif
    if (sh_amt == '0) begin
      y = val;
    end else if (sh_amt >= D_FLUSH) begin
      y = '0;
    end else begin
      y = val >>> sh_amt;
`ifdef MRD_BFP_ALIGN_RND_EN
      y = y + {{(DW-1){1'b0}}, val[dm1]};
`endif
    end
    return y;
  endfunction

  assign accept  = in_val & in_rdy_q;
  assign start   = accept & in_sop;
  assign in_fill = (state_q == ST_FILL);
  assign drop    = accept & in_fill & ~in_sop & (wr_cnt_q == LEN_MAX);
  assign upd     = accept & in_fill & ~in_sop & ~drop;
  assign wr_en   = start | upd;
  assign wr_addr = in_sop ? '0 : wr_cnt_q[AW-1:0];

  assign rsb_re  = rsb(din_real);
  assign rsb_im  = rsb(din_imag);
  assign smp_rsb = (rsb_re < rsb_im) ? rsb_re : rsb_im;
  assign smp_key = $signed({1'b0, smp_rsb}) - $signed({2'b00, exp_in});

  assign w_smp.re = din_real;
  assign w_smp.im = din_imag;

  assign rd_en   = (state_q == ST_DRAIN) && (rd_cnt_q < wr_cnt_q);
  assign rd_last = (rd_cnt_q == wr_cnt_q - CNT_ONE);

  mrd_sdp_ram #(
    .DEPTH (FRAME_MAX),
    .AW    (AW),
    .WW    (WW)
  ) u_ram (
    .clk       (clk),
    .wr_en_i   (wr_en),
    .wr_addr_i (wr_addr),
    .wr_data_i ({exp_in, w_smp}),
    .rd_en_i   (rd_en),
    .rd_addr_i (rd_cnt_q[AW-1:0]),
    .rd_data_o (rd_data)
  );

  assign r_exp = rd_data[WW-1 -: EXPW];
  assign r_smp = cplx_t'(rd_data[2*DW-1:0]);
  assign d     = {1'b0, max_exp_q} - {1'b0, r_exp};

  // Frame state, write count and the max-exponent / min-headroom trackers.
  always_comb begin
    state_d   = state_q;
    wr_cnt_d  = wr_cnt_q;
    max_exp_d = max_exp_q;
    mt_d      = mt_q;
    ovf_d     = ovf_q;
    if (start) begin
      wr_cnt_d  = CNT_ONE;
      max_exp_d = exp_in;
      mt_d      = smp_key;
      ovf_d     = 1'b0;
    end else if (upd) begin
      wr_cnt_d = wr_cnt_q + CNT_ONE;
      if (exp_in > max_exp_q) max_exp_d = exp_in;
      if (smp_key < mt_q) mt_d = smp_key;
    end else if (drop) begin
      ovf_d = 1'b1;
    end
    case (state_q)
      ST_IDLE:  if (start) state_d = in_eop ? ST_DRAIN : ST_FILL;
      ST_FILL:  if (accept && in_eop) state_d = ST_DRAIN;
      ST_DRAIN: if (out_eop_q) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
    rd_cnt_d = (state_q == ST_DRAIN) ? (rd_en ? rd_cnt_q + CNT_ONE : rd_cnt_q) : '0;
  end

  // Control registers; in_rdy is registered so it stays low throughout reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      in_rdy_q  <= 1'b0;
      wr_cnt_q  <= '0;
      rd_cnt_q  <= '0;
      max_exp_q <= '0;
      mt_q      <= '0;
      ovf_q     <= 1'b0;
      err_ovf_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      in_rdy_q  <= (state_d != ST_DRAIN);
      wr_cnt_q  <= wr_cnt_d;
      rd_cnt_q  <= rd_cnt_d;
      max_exp_q <= max_exp_d;
      mt_q      <= mt_d;
      ovf_q     <= ovf_d;
      err_ovf_q <= drop & ~ovf_q;
    end
  end

  // Read pipeline: flags travel alongside the RAM read, then the aligned sample is registered.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_val_q  <= 1'b0;
      s1_sop_q  <= 1'b0;
      s1_eop_q  <= 1'b0;
      out_val_q <= 1'b0;
      out_sop_q <= 1'b0;
      out_eop_q <= 1'b0;
      dout_re_q <= '0;
      dout_im_q <= '0;
    end else begin
      s1_val_q  <= rd_en;
      s1_sop_q  <= rd_en && (rd_cnt_q == '0);
      s1_eop_q  <= rd_en && rd_last;
      out_val_q <= s1_val_q;
      out_sop_q <= s1_sop_q;
      out_eop_q <= s1_eop_q;
      if (s1_val_q) begin
        dout_re_q <= align(r_smp.re, d);
        dout_im_q <= align(r_smp.im, d);
      end else begin
        dout_re_q <= '0;
        dout_im_q <= '0;
      end
    end
  end

  assign msum = $signed({mt_q[5], mt_q}) + $signed({3'b000, max_exp_q});

  assign in_rdy     = in_rdy_q;
  assign out_val    = out_val_q;
  assign out_sop    = out_sop_q;
  assign out_eop    = out_eop_q;
  assign dout_real  = dout_re_q;
  assign dout_imag  = dout_im_q;
  assign err_ovf    = err_ovf_q;
  assign exp_out    = out_val_q ? max_exp_q : '0;
  assign margin_out = !out_val_q           ? 2'd0 :
                      msum[6]              ? 2'd0 :
                      (msum > 7'sd3)       ? MARGIN_MAX :
                                             msum[1:0];

endmodule

// File: tb/tb_mrd_bfp_align.sv
// tb/tb_mrd_bfp_align.sv - directed self-checking bench for mrd_bfp_align
module tb_mrd_bfp_align;

  localparam int FM = 8;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               in_val = 1'b0, in_sop = 1'b0, in_eop = 1'b0;
  logic signed [17:0] din_real = '0, din_imag = '0;
  logic [3:0]         exp_in = '0;
  logic               in_rdy, out_val, out_sop, out_eop, err_ovf;
  logic signed [17:0] dout_real, dout_imag;
  logic [3:0]         exp_out;
  logic [1:0]         margin_out;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  mrd_bfp_align #(.FRAME_MAX(FM)) dut (
    .clk(clk), .rst_n(rst_n), .in_val(in_val), .in_sop(in_sop), .in_eop(in_eop),
    .din_real(din_real), .din_imag(din_imag), .exp_in(exp_in), .in_rdy(in_rdy),
    .out_val(out_val), .out_sop(out_sop), .out_eop(out_eop), .dout_real(dout_real),
    .dout_imag(dout_imag), .exp_out(exp_out), .margin_out(margin_out), .err_ovf(err_ovf)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int re; int im; bit sop; bit eop; int ex; int mg; bit rdy; int c;
  } osmp_t;
  osmp_t oq[$];
  int ovf_cnt = 0;
  int ovf_cyc = 0;

  always @(negedge clk) begin
    osmp_t s;
    if (out_val) begin
      s.re = dout_real; s.im = dout_imag; s.sop = out_sop; s.eop = out_eop;
      s.ex = exp_out; s.mg = margin_out; s.rdy = in_rdy; s.c = cyc;
      oq.push_back(s);
    end
    if (err_ovf) begin
      ovf_cnt++;
      ovf_cyc = cyc;
    end
  end

  int s_re[16], s_im[16], s_ex[16], acc_cyc[16];
  bit s_sop[16], s_eop[16];
  int n_s = 0;
  int e_re[16], e_im[16];

  task automatic chk(input string tag, input int got, input int want);
    n_tests++;
    if (got != want) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, want);
    end
  endtask

  task automatic clr();
    oq.delete();
    n_s = 0;
    ovf_cnt = 0;
  endtask

  task automatic put(input int re, input int im, input int ex, input bit sop, input bit eop);
    s_re[n_s] = re; s_im[n_s] = im; s_ex[n_s] = ex; s_sop[n_s] = sop; s_eop[n_s] = eop;
    n_s++;
  endtask

  task automatic send();
    for (int k = 0; k < n_s; k++) begin
      int wt = 0;
      while (!in_rdy && wt < 50) begin
        @(posedge clk); #1; wt++;
      end
      if (wt >= 50) chk("rdy_wait", in_rdy, 1);
      in_val = 1'b1; in_sop = s_sop[k]; in_eop = s_eop[k];
      din_real = 18'(s_re[k]); din_imag = 18'(s_im[k]); exp_in = 4'(s_ex[k]);
      @(posedge clk); #1;
      acc_cyc[k] = cyc;
      in_val = 1'b0; in_sop = 1'b0; in_eop = 1'b0;
    end
  endtask

  task automatic wait_out(input string tag);
    int wt = 0;
    while (!(oq.size() > 0 && oq[oq.size()-1].eop) && wt < 100) begin
      @(negedge clk); #1; wt++;
    end
    if (wt >= 100) chk({tag, "_timeout"}, 0, 1);
  endtask

  task automatic chk_frame(input string tag, input int n, input int ex, input int mg);
    chk({tag, "_len"}, oq.size(), n);
    if (oq.size() == n) begin
      for (int k = 0; k < n; k++) begin
        chk($sformatf("%s_re%0d", tag, k), oq[k].re, e_re[k]);
        chk($sformatf("%s_im%0d", tag, k), oq[k].im, e_im[k]);
        chk($sformatf("%s_sop%0d", tag, k), int'(oq[k].sop), (k == 0) ? 1 : 0);
        chk($sformatf("%s_eop%0d", tag, k), int'(oq[k].eop), (k == n - 1) ? 1 : 0);
        chk($sformatf("%s_exp%0d", tag, k), oq[k].ex, ex);
        chk($sformatf("%s_mrg%0d", tag, k), oq[k].mg, mg);
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rdy", in_rdy, 0);
    chk("rst_val", out_val, 0);
    chk("rst_exp", exp_out, 0);
    chk("rst_mrg", margin_out, 0);
    chk("rst_ovf", err_ovf, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rdy_after_rst", in_rdy, 1);

    // equal exponents: data passes unchanged
    clr();
    put(1000, 3, 2, 1, 0); put(-1000, -3, 2, 0, 0); put(5, 7, 2, 0, 0); put(0, -1, 2, 0, 1);
    e_re[0] = 1000; e_im[0] = 3; e_re[1] = -1000; e_im[1] = -3;
    e_re[2] = 5;    e_im[2] = 7; e_re[3] = 0;     e_im[3] = -1;
    send();
    wait_out("eq");
    chk_frame("eq", 4, 2, 3);
    if (oq.size() == 4) begin
      chk("eq_latency", oq[0].c - acc_cyc[3], 2);
      chk("eq_rdy_at_eop", int'(oq[3].rdy), 0);
    end
    chk("eq_no_ovf", ovf_cnt, 0);
    @(posedge clk); #1;
    chk("eq_rdy_after_eop", in_rdy, 1);

    // mixed exponents: exact shifts
    clr();
    put(400, -800, 0, 1, 0); put(100, 40, 3, 0, 1);
    e_re[0] = 50; e_im[0] = -100; e_re[1] = 100; e_im[1] = 40;
    send();
    wait_out("mix");
    chk_frame("mix", 2, 3, 3);

    // rounding versus truncation on a one-bit shift
    clr();
    put(7, -7, 0, 1, 0); put(0, 0, 1, 0, 1);
`ifdef MRD_BFP_ALIGN_RND_EN
    e_re[0] = 4; e_im[0] = -3;
`else
    e_re[0] = 3; e_im[0] = -4;
`endif
    e_re[1] = 0; e_im[1] = 0;
    send();
    wait_out("rnd");
    chk_frame("rnd", 2, 1, 3);

    // margin from min(rsb - exp) + max_exp, clamped at 3
    clr();
    put(1024, -1024, 0, 1, 0); put(1024, -1024, 4, 0, 0); put(-1024, 1024, 0, 0, 1);
    e_re[0] = 64; e_im[0] = -64; e_re[1] = 1024; e_im[1] = -1024; e_re[2] = -64; e_im[2] = 64;
    send();
    wait_out("mrg");
    chk_frame("mrg", 3, 4, 3);

    // one-sample frames: full scale gives 0, then headroom 1 and 2
    clr();
    put(131071, 0, 0, 1, 1);
    e_re[0] = 131071; e_im[0] = 0;
    send();
    wait_out("fs");
    chk_frame("fs", 1, 0, 0);

    clr();
    put(40000, 0, 0, 1, 1);
    e_re[0] = 40000; e_im[0] = 0;
    send();
    wait_out("m1");
    chk_frame("m1", 1, 0, 1);

    clr();
    put(0, -20000, 0, 1, 1);
    e_re[0] = 0; e_im[0] = -20000;
    send();
    wait_out("m2");
    chk_frame("m2", 1, 0, 2);

    // overflow: 10 samples into an 8-deep buffer, dropped sample carries a larger exponent
    clr();
    for (int k = 0; k < 10; k++) put(k * 10 + 1, -k, (k == 8) ? 5 : 0, k == 0, k == 9);
    for (int k = 0; k < 8; k++) begin
      e_re[k] = k * 10 + 1; e_im[k] = -k;
    end
    send();
    wait_out("ovf");
    chk_frame("ovf", 8, 0, 3);
    chk("ovf_pulses", ovf_cnt, 1);
    chk("ovf_at_sample9", ovf_cyc, acc_cyc[8]);

    // sop inside FILL restarts the frame and the trackers
    clr();
    put(500, 0, 7, 1, 0); put(600, 0, 7, 0, 0); put(30, -30, 1, 1, 0); put(-2, 2, 0, 0, 1);
    e_re[0] = 30; e_im[0] = -30; e_re[1] = -1; e_im[1] = 1;
    send();
    wait_out("rst_sop");
    chk_frame("rst_sop", 2, 1, 3);

    // reset mid-FILL discards the frame; stray valid in IDLE is ignored
    clr();
    put(11, 12, 1, 1, 0); put(13, 14, 1, 0, 0); put(15, 16, 1, 0, 0);
    send();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    chk("rst_mid_no_out", oq.size(), 0);
    clr();
    put(99, 99, 3, 0, 0); put(-5, 6, 2, 1, 0); put(8, -9, 2, 0, 1);
    e_re[0] = -5; e_im[0] = 6; e_re[1] = 8; e_im[1] = -9;
    send();
    wait_out("post_rst");
    chk_frame("post_rst", 2, 2, 3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
